// File: rtl/cursor_pkg.sv
// Shared definitions for the tile-game cursor/selection controller.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
//
// Contents:
//   op_e    - user command encodings from the input decoder
//   state_e - controller state encoding
//   DEF_*   - default grid dimensions
//   helpers - direction classification of an op
package cursor_pkg;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_SELECT = 3'd1,
    OP_CANCEL = 3'd2,
    OP_LEFT   = 3'd3,
    OP_RIGHT  = 3'd4,
    OP_UP     = 3'd5,
    OP_DOWN   = 3'd6,
    OP_RSVD   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_ELIM = 2'd2,
    ST_SWAP = 2'd3
  } state_e;

  localparam int DEF_GRID_W = 8;
  localparam int DEF_GRID_H = 8;

  // True for any of the four cursor-movement ops.
  function automatic logic is_dir(input op_e o);
    return (o == OP_LEFT) || (o == OP_RIGHT) || (o == OP_UP) || (o == OP_DOWN);
  endfunction

  // True for ops that move along x; the other directions move along y.
  function automatic logic is_horiz(input op_e o);
    return (o == OP_LEFT) || (o == OP_RIGHT);
  endfunction

endpackage

// File: rtl/cursor_ctrl_step_coord.sv
// Per-axis next-coordinate calculator for one cursor step (+1 or -1).
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
//
// Ports:
//   coord     - current coordinate on this axis
//   dir       - 1 = step towards limit (+1), 0 = step towards zero (-1)
//   limit     - largest legal coordinate on this axis (grid size - 1)
//   wrap_en   - 1 = stepping off an edge lands on the opposite edge
//   step      - resulting coordinate (holds at the edge when wrap_en = 0)
//   in_bounds - 1 when the unwrapped neighbour lies inside the grid
module step_coord #(
  parameter int W = 4
) (
  input  logic [W-1:0] coord,
  input  logic         dir,
  input  logic [W-1:0] limit,
  input  logic         wrap_en,
  output logic [W-1:0] step,
  output logic         in_bounds
);

  always_comb begin
    step      = coord;
    in_bounds = 1'b1;
    if (dir) begin
      // '>=' rather than '==' so an out-of-range coordinate never runs away
      if (coord >= limit) begin
        in_bounds = 1'b0;
        if (wrap_en) step = '0;
      end else begin
        step = coord + 1'b1;
      end
    end else begin
      if (coord == '0) begin
        in_bounds = 1'b0;
        if (wrap_en) step = limit;
      end else begin
        step = coord - 1'b1;
      end
    end
  end

endmodule

// File: rtl/cursor_ctrl.sv
// Cursor/selection controller: moves the cursor, manages the selection and
// issues eliminate/swap requests to the board engine with an ack timeout.
// Latency: every accepted op and every ack shows its effect one cycle later.
// Backpressure: op_ready is low while an eliminate or swap request is open.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   op, op_valid        - user command and its valid; accepted when op_ready
//   op_ready            - high in IDLE and SEL
//   cur_x, cur_y        - cursor cell
//   selected            - a cell is selected; sel_x/sel_y hold it
//   elim_req            - eliminate the group at sel_x/sel_y (held until done)
//   swap_req            - swap sel cell with tgt_x/tgt_y (held until done)
//   elim_ack, swap_ack  - completion strobes; swap_ok qualifies swap_ack
//   err                 - one-cycle pulse: bad swap direction, rejected swap, timeout
//   move_cnt            - completed moves, saturating
module cursor_ctrl
  import cursor_pkg::*;
#(
  parameter int GRID_W      = DEF_GRID_W,
  parameter int GRID_H      = DEF_GRID_H,
  parameter int XW          = 4,
  parameter int YW          = 4,
  parameter int WRAP        = 0,
  parameter int ACK_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       op,
  input  logic             op_valid,
  output logic             op_ready,
  output logic [XW-1:0]    cur_x,
  output logic [YW-1:0]    cur_y,
  output logic             selected,
  output logic [XW-1:0]    sel_x,
  output logic [YW-1:0]    sel_y,
  output logic             elim_req,
  output logic             swap_req,
  output logic [XW-1:0]    tgt_x,
  output logic [YW-1:0]    tgt_y,
  input  logic             elim_ack,
  input  logic             swap_ack,
  input  logic             swap_ok,
  output logic             err,
  output logic [CNT_W-1:0] move_cnt
);

  localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);

  // The counter only has to hold 0..ACK_TIMEOUT-1: the abort happens on the
  // edge where it would otherwise reach ACK_TIMEOUT, so a request stays up
  // for exactly ACK_TIMEOUT cycles.
  localparam int            TW       = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  state_e        state;
  logic [TW-1:0] tmo_cnt;

  op_e           op_c;
  logic          wrap_en;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  logic          x_ok;
  logic          y_ok;
  logic [XW-1:0] nb_x;
  logic [YW-1:0] nb_y;
  logic          nb_ok;
  logic          expired;

  assign op_c     = op_e'(op);
  assign op_ready = (state == ST_IDLE) || (state == ST_SEL);
  assign expired  = (tmo_cnt == TMO_LAST);

  // Wrapping only applies to free cursor movement; a swap neighbour is
  // taken from in_bounds, which ignores wrap_en, so it never wraps anyway.
  assign wrap_en = (WRAP != 0) && (state == ST_IDLE);

  step_coord #(.W(XW)) u_step_x (
    .coord     (cur_x),
    .dir       (op_c == OP_RIGHT),
    .limit     (X_MAX),
    .wrap_en   (wrap_en),
    .step      (nx),
    .in_bounds (x_ok)
  );

  step_coord #(.W(YW)) u_step_y (
    .coord     (cur_y),
    .dir       (op_c == OP_DOWN),
    .limit     (Y_MAX),
    .wrap_en   (wrap_en),
    .step      (ny),
    .in_bounds (y_ok)
  );

  // In SEL the cursor always sits on the selected cell (every exit from
  // SWAP back to SEL restores it), so the cursor neighbour is the sel
  // neighbour.
  always_comb begin
    nb_x  = cur_x;
    nb_y  = cur_y;
    nb_ok = 1'b0;
    if (is_horiz(op_c)) begin
      nb_x  = nx;
      nb_ok = x_ok;
    end else if (is_dir(op_c)) begin
      nb_y  = ny;
      nb_ok = y_ok;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      tmo_cnt  <= '0;
      cur_x    <= '0;
      cur_y    <= '0;
      sel_x    <= '0;
      sel_y    <= '0;
      tgt_x    <= '0;
      tgt_y    <= '0;
      selected <= 1'b0;
      elim_req <= 1'b0;
      swap_req <= 1'b0;
      err      <= 1'b0;
      move_cnt <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (op_valid) begin
            if (op_c == OP_SELECT) begin
              sel_x    <= cur_x;
              sel_y    <= cur_y;
              selected <= 1'b1;
              tmo_cnt  <= '0;
              state    <= ST_SEL;
            end else if (is_dir(op_c)) begin
              // At a non-wrapping edge step_coord returns the same coordinate.
              cur_x <= nb_x;
              cur_y <= nb_y;
            end
          end
        end

        ST_SEL: begin
          if (op_valid) begin
            if (op_c == OP_SELECT) begin
              elim_req <= 1'b1;
              tmo_cnt  <= '0;
              state    <= ST_ELIM;
            end else if (op_c == OP_CANCEL) begin
              selected <= 1'b0;
              tmo_cnt  <= '0;
              state    <= ST_IDLE;
            end else if (is_dir(op_c)) begin
              if (nb_ok) begin
                tgt_x    <= nb_x;
                tgt_y    <= nb_y;
                cur_x    <= nb_x;
                cur_y    <= nb_y;
                swap_req <= 1'b1;
                tmo_cnt  <= '0;
                state    <= ST_SWAP;
              end else begin
                err <= 1'b1;
              end
            end
          end
        end

        ST_ELIM: begin
          // Ack is checked first so an ack on the expiry cycle still succeeds.
          if (elim_ack) begin
            elim_req <= 1'b0;
            selected <= 1'b0;
            if (move_cnt != '1) move_cnt <= move_cnt + 1'b1;
            tmo_cnt  <= '0;
            state    <= ST_IDLE;
          end else if (expired) begin
            elim_req <= 1'b0;
            err      <= 1'b1;
            cur_x    <= sel_x;
            cur_y    <= sel_y;
            tmo_cnt  <= '0;
            state    <= ST_SEL;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        ST_SWAP: begin
          if (swap_ack) begin
            swap_req <= 1'b0;
            tmo_cnt  <= '0;
            if (swap_ok) begin
              selected <= 1'b0;
              if (move_cnt != '1) move_cnt <= move_cnt + 1'b1;
              state    <= ST_IDLE;
            end else begin
              // Rejected swap: keep the selection and put the cursor back on it.
              err   <= 1'b1;
              cur_x <= sel_x;
              cur_y <= sel_y;
              state <= ST_SEL;
            end
          end else if (expired) begin
            swap_req <= 1'b0;
            err      <= 1'b1;
            cur_x    <= sel_x;
            cur_y    <= sel_y;
            tmo_cnt  <= '0;
            state    <= ST_SEL;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cursor_ctrl.sv
// Testbench for cursor_ctrl: two instances (non-wrapping/16-bit counter and
// wrapping/2-bit counter) driven by directed steps; the expected output
// snapshot of each step is queued when driven and compared after the edge.
module tb_cursor_ctrl;
  import cursor_pkg::*;

  localparam int AT = 12;

  typedef struct packed {
    logic [3:0]  cx;
    logic [3:0]  cy;
    logic        sl;
    logic [3:0]  sx;
    logic [3:0]  sy;
    logic        er;
    logic        sr;
    logic [3:0]  tx;
    logic [3:0]  ty;
    logic        e;
    logic        rdy;
    logic [15:0] cnt;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n    [2];
  logic [2:0]  op       [2];
  logic        op_valid [2];
  logic        op_ready [2];
  logic [3:0]  cur_x    [2];
  logic [3:0]  cur_y    [2];
  logic        selected [2];
  logic [3:0]  sel_x    [2];
  logic [3:0]  sel_y    [2];
  logic        elim_req [2];
  logic        swap_req [2];
  logic [3:0]  tgt_x    [2];
  logic [3:0]  tgt_y    [2];
  logic        elim_ack [2];
  logic        swap_ack [2];
  logic        swap_ok  [2];
  logic        err      [2];
  logic [15:0] move_cnt0;
  logic [1:0]  move_cnt1;

  cursor_ctrl #(.GRID_W(8), .GRID_H(8), .XW(4), .YW(4), .WRAP(0),
                .ACK_TIMEOUT(AT), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .op(op[0]), .op_valid(op_valid[0]),
    .op_ready(op_ready[0]), .cur_x(cur_x[0]), .cur_y(cur_y[0]),
    .selected(selected[0]), .sel_x(sel_x[0]), .sel_y(sel_y[0]),
    .elim_req(elim_req[0]), .swap_req(swap_req[0]), .tgt_x(tgt_x[0]),
    .tgt_y(tgt_y[0]), .elim_ack(elim_ack[0]), .swap_ack(swap_ack[0]),
    .swap_ok(swap_ok[0]), .err(err[0]), .move_cnt(move_cnt0)
  );

  cursor_ctrl #(.GRID_W(8), .GRID_H(8), .XW(4), .YW(4), .WRAP(1),
                .ACK_TIMEOUT(AT), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .op(op[1]), .op_valid(op_valid[1]),
    .op_ready(op_ready[1]), .cur_x(cur_x[1]), .cur_y(cur_y[1]),
    .selected(selected[1]), .sel_x(sel_x[1]), .sel_y(sel_y[1]),
    .elim_req(elim_req[1]), .swap_req(swap_req[1]), .tgt_x(tgt_x[1]),
    .tgt_y(tgt_y[1]), .elim_ack(elim_ack[1]), .swap_ack(swap_ack[1]),
    .swap_ok(swap_ok[1]), .err(err[1]), .move_cnt(move_cnt1)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  obs_t  want [2];
  obs_t  exp_q [$];
  string tag_q [$];
  int    idx_q [$];

  function automatic obs_t reset_obs();
    obs_t r;
    r     = '0;
    r.rdy = 1'b1;
    return r;
  endfunction

  function automatic obs_t sample(input int i);
    obs_t s;
    s.cx  = cur_x[i];
    s.cy  = cur_y[i];
    s.sl  = selected[i];
    s.sx  = sel_x[i];
    s.sy  = sel_y[i];
    s.er  = elim_req[i];
    s.sr  = swap_req[i];
    s.tx  = tgt_x[i];
    s.ty  = tgt_y[i];
    s.e   = err[i];
    s.rdy = op_ready[i];
    s.cnt = (i == 0) ? move_cnt0 : {14'd0, move_cnt1};
    return s;
  endfunction

  // Fields in order: cx cy sl sx sy er sr tx ty err rdy cnt
  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp_v);
    end
  endtask

  task automatic push(input int i, input string tag);
    exp_q.push_back(want[i]);
    tag_q.push_back(tag);
    idx_q.push_back(i);
    want[i].e = 1'b0;  // err is a single-cycle pulse
  endtask

  task automatic pop_check();
    obs_t  e;
    string t;
    int    i;
    if (exp_q.size() == 0) begin
      check_val("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      i = idx_q.pop_front();
      check_val($sformatf("%s[dut%0d]", t, i), 64'(sample(i)), 64'(e));
    end
  endtask

  task automatic check_now(input int i, input string tag);
    push(i, tag);
    pop_check();
  endtask

  // Drive one cycle of stimulus from a negedge, compare at the next negedge.
  task automatic step(input int i, input logic [2:0] o, input logic v,
                      input logic ea, input logic sa, input logic ok, input string tag);
    op[i]       = o;
    op_valid[i] = v;
    elim_ack[i] = ea;
    swap_ack[i] = sa;
    swap_ok[i]  = ok;
    push(i, tag);
    @(negedge clk);
    op_valid[i] = 1'b0;
    elim_ack[i] = 1'b0;
    swap_ack[i] = 1'b0;
    swap_ok[i]  = 1'b0;
    pop_check();
  endtask

  task automatic do_op(input int i, input logic [2:0] o, input string tag);
    step(i, o, 1'b1, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic idle(input int i, input string tag);
    step(i, OP_NOP, 1'b0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_n[i]    = 1'b0;
      op[i]       = 3'd0;
      op_valid[i] = 1'b0;
      elim_ack[i] = 1'b0;
      swap_ack[i] = 1'b0;
      swap_ok[i]  = 1'b0;
      want[i]     = reset_obs();
    end
    @(negedge clk);
    check_now(0, "reset");
    check_now(1, "reset");
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // Edge handling in IDLE: hold without wrap, wrap when enabled
    do_op(0, OP_LEFT, "left_hold");
    do_op(0, OP_UP, "up_hold");
    do_op(0, OP_CANCEL, "cancel_idle");
    do_op(0, OP_RSVD, "rsvd_idle");
    want[1].cx = 4'd7; do_op(1, OP_LEFT, "left_wrap");
    want[1].cy = 4'd7; do_op(1, OP_UP, "up_wrap");
    want[1].cx = 4'd0; do_op(1, OP_RIGHT, "right_wrap");
    want[1].cy = 4'd0; do_op(1, OP_DOWN, "down_wrap");

    // Move to (3,2), select, eliminate with ack in the fifth cycle
    for (int k = 1; k <= 3; k++) begin want[0].cx = 4'(k); do_op(0, OP_RIGHT, "right"); end
    for (int k = 1; k <= 2; k++) begin want[0].cy = 4'(k); do_op(0, OP_DOWN, "down"); end
    want[0].sl = 1'b1; want[0].sx = 4'd3; want[0].sy = 4'd2;
    do_op(0, OP_SELECT, "select_32");
    want[0].er = 1'b1; want[0].rdy = 1'b0;
    do_op(0, OP_SELECT, "elim_req");
    idle(0, "elim_hold");
    do_op(0, OP_CANCEL, "elim_ign_op");
    idle(0, "elim_hold");
    step(0, OP_NOP, 1'b0, 1'b0, 1'b1, 1'b1, "elim_ign_swap_ack");
    want[0].er = 1'b0; want[0].sl = 1'b0; want[0].rdy = 1'b1; want[0].cnt = 16'd1;
    step(0, OP_NOP, 1'b0, 1'b1, 1'b0, 1'b0, "elim_ack");
    step(0, OP_NOP, 1'b0, 1'b1, 1'b0, 1'b0, "idle_ign_ack");

    // Swap up from (3,2): rejected, then accepted
    want[0].sl = 1'b1;
    do_op(0, OP_SELECT, "select_swap");
    want[0].sr = 1'b1; want[0].tx = 4'd3; want[0].ty = 4'd1; want[0].cy = 4'd1; want[0].rdy = 1'b0;
    do_op(0, OP_UP, "swap_req");
    step(0, OP_NOP, 1'b0, 1'b1, 1'b0, 1'b0, "swap_ign_elim_ack");
    want[0].sr = 1'b0; want[0].cy = 4'd2; want[0].e = 1'b1; want[0].rdy = 1'b1;
    step(0, OP_NOP, 1'b0, 1'b0, 1'b1, 1'b0, "swap_reject");
    idle(0, "err_one_cycle");
    want[0].sr = 1'b1; want[0].cy = 4'd1; want[0].rdy = 1'b0;
    do_op(0, OP_UP, "swap_req2");
    want[0].sr = 1'b0; want[0].sl = 1'b0; want[0].rdy = 1'b1; want[0].cnt = 16'd2;
    step(0, OP_NOP, 1'b0, 1'b0, 1'b1, 1'b1, "swap_ok");

    // Selected at (0,0): out-of-grid swap directions raise err only
    for (int k = 2; k >= 0; k--) begin want[0].cx = 4'(k); do_op(0, OP_LEFT, "left"); end
    want[0].cy = 4'd0; do_op(0, OP_UP, "up");
    want[0].sl = 1'b1; want[0].sx = 4'd0; want[0].sy = 4'd0;
    do_op(0, OP_SELECT, "select_00");
    want[0].e = 1'b1; do_op(0, OP_LEFT, "sel_left_edge");
    want[0].e = 1'b1; do_op(0, OP_UP, "sel_up_edge");

    // Eliminate timeout, then ack landing on the expiry cycle
    want[0].er = 1'b1; want[0].rdy = 1'b0;
    do_op(0, OP_SELECT, "elim_to_start");
    repeat (AT - 1) idle(0, "elim_to_hold");
    want[0].er = 1'b0; want[0].e = 1'b1; want[0].rdy = 1'b1;
    idle(0, "elim_timeout");
    idle(0, "post_timeout");
    want[0].er = 1'b1; want[0].rdy = 1'b0;
    do_op(0, OP_SELECT, "elim_to_start2");
    repeat (AT - 1) idle(0, "elim_to_hold2");
    want[0].er = 1'b0; want[0].sl = 1'b0; want[0].rdy = 1'b1; want[0].cnt = 16'd3;
    step(0, OP_NOP, 1'b0, 1'b1, 1'b0, 1'b0, "ack_on_timeout");

    // Swap timeout returns the cursor to the selection
    want[0].sl = 1'b1;
    do_op(0, OP_SELECT, "select_00b");
    want[0].sr = 1'b1; want[0].tx = 4'd1; want[0].ty = 4'd0; want[0].cx = 4'd1; want[0].rdy = 1'b0;
    do_op(0, OP_RIGHT, "swap_right");
    repeat (AT - 1) idle(0, "swap_to_hold");
    want[0].sr = 1'b0; want[0].e = 1'b1; want[0].cx = 4'd0; want[0].rdy = 1'b1;
    idle(0, "swap_timeout");
    want[0].sl = 1'b0;
    do_op(0, OP_CANCEL, "cancel_sel");

    // Asynchronous reset while a swap request is open
    want[0].sl = 1'b1;
    do_op(0, OP_SELECT, "select_rst");
    want[0].sr = 1'b1; want[0].tx = 4'd0; want[0].ty = 4'd1; want[0].cy = 4'd1; want[0].rdy = 1'b0;
    do_op(0, OP_DOWN, "swap_before_rst");
    rst_n[0] = 1'b0;
    #2;
    want[0] = reset_obs();
    check_now(0, "async_reset");
    @(negedge clk);
    check_now(0, "reset_held");
    rst_n[0] = 1'b1;

    // Wrapping instance: selected swaps still never wrap
    want[1].sl = 1'b1;
    do_op(1, OP_SELECT, "wrap_select_00");
    want[1].e = 1'b1; do_op(1, OP_LEFT, "wrap_sel_left");
    want[1].e = 1'b1; do_op(1, OP_UP, "wrap_sel_up");
    want[1].sl = 1'b0;
    do_op(1, OP_CANCEL, "wrap_cancel");

    // 2-bit move counter saturates at 3
    for (int k = 1; k <= 5; k++) begin
      want[1].sl = 1'b1;
      do_op(1, OP_SELECT, "sat_select");
      want[1].er = 1'b1; want[1].rdy = 1'b0;
      do_op(1, OP_SELECT, "sat_elim");
      want[1].er = 1'b0; want[1].sl = 1'b0; want[1].rdy = 1'b1;
      want[1].cnt = (k > 3) ? 16'd3 : 16'(k);
      step(1, OP_NOP, 1'b0, 1'b1, 1'b0, 1'b0, "sat_cnt");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cursor_ctrl.md
Name: cursor_ctrl

Overview:
Parametrised cursor/selection controller for the tile-elimination game grid; replaces the fixed 8x8 cursor/select logic.
Takes one-operation-per-handshake user commands from the input decoder, moves the cursor and manages selection.
Issues either an eliminate request or a swap request to the board engine over a req/ack handshake, with an acknowledge timeout.
Tracks a saturating move counter for the score/display path.

Parameters:
GRID_W, 8, number of columns (x range 0..GRID_W-1)
GRID_H, 8, number of rows (y range 0..GRID_H-1)
XW, 4, x coordinate width; must satisfy 2**XW >= GRID_W
YW, 4, y coordinate width; must satisfy 2**YW >= GRID_H
WRAP, 0, 1 = cursor wraps at grid edges while unselected; 0 = cursor holds at the edge
ACK_TIMEOUT, 255, cycles to wait for elim_ack/swap_ack before aborting
CNT_W, 16, move counter width

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
op  in  3  0 NOP, 1 SELECT, 2 CANCEL, 3 LEFT, 4 RIGHT, 5 UP, 6 DOWN, 7 reserved
op_valid  in  1  op is presented
op_ready  out  1  controller can accept an op
cur_x / cur_y  out  XW / YW  cursor cell
selected  out  1  a cell is selected
sel_x / sel_y  out  XW / YW  selected cell, valid while selected=1
elim_req  out  1  request to eliminate the group at sel_x/sel_y
swap_req  out  1  request to swap sel cell with tgt cell
tgt_x / tgt_y  out  XW / YW  swap target cell
elim_ack / swap_ack  in  1  board engine completion strobes
swap_ok  in  1  sampled with swap_ack; 1 = swap produced a match
err  out  1  one-cycle pulse: illegal swap direction, rejected swap, or timeout
move_cnt  out  CNT_W  completed moves, saturates at all-ones

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE; cursor (0,0); sel (0,0); tgt (0,0).
  - selected, elim_req, swap_req, err = 0; move_cnt = 0; timeout counter = 0.
- op_ready = 1 in IDLE and SEL only.
- An op is accepted on a clock edge with op_valid & op_ready. All effects appear one cycle later (registered outputs). NOP and reserved ops are accepted with no effect.
- IDLE (selected=0):
  - SELECT: sel <= cursor; selected <= 1; go to SEL.
  - CANCEL: no effect.
  - LEFT/RIGHT/UP/DOWN: move the cursor one cell. UP decrements y; DOWN increments y.
  - At an edge with WRAP=0: the cursor holds and no err is raised.
  - At an edge with WRAP=1: 0 <-> GRID_W-1 for x, 0 <-> GRID_H-1 for y.
- SEL (selected=1):
  - SELECT: go to ELIM; elim_req <= 1.
  - CANCEL: selected <= 0; go to IDLE; cursor stays where it is.
  - Direction op with an in-bounds neighbour (never wraps, regardless of WRAP): tgt <= neighbour; cursor <= neighbour; swap_req <= 1; go to SWAP.
  - Direction op with an out-of-bounds neighbour: err pulse; stay in SEL.
- ELIM:
  - elim_req is held high and the timeout counter increments each cycle.
  - elim_ack: elim_req <= 0, selected <= 0, move_cnt++ (saturating), go to IDLE.
- SWAP:
  - swap_req is held high and the timeout counter increments each cycle.
  - swap_ack with swap_ok=1: swap_req <= 0, selected <= 0, move_cnt++, go to IDLE.
  - swap_ack with swap_ok=0: swap_req <= 0, cursor <= sel, err pulse, return to SEL with the selection retained.
- Timeout: when the counter reaches ACK_TIMEOUT without an ack, drop the request, raise an err pulse, cursor <= sel, return to SEL. The counter is cleared on every state entry.
- Simultaneous ack and timeout expiry in the same cycle: ack wins.
- Acks outside the matching state are ignored. swap_ack in ELIM and elim_ack in SWAP are ignored.
- err is high for exactly one cycle per event.
- Reset asserted mid-request drops the request immediately (async).

Decomposition:
- Shared game package (cursor_pkg):
  - op encodings OP_NOP..OP_DOWN
  - state encoding IDLE/SEL/ELIM/SWAP
  - default GRID_W/GRID_H
- Sub-module step_coord: combinational per-axis next coordinate plus an in-bounds flag.
  - Inputs: coordinate, dir (+1/-1), limit, wrap_en.
  - Instantiated once for x and once for y.

Test Plan:
- Reset, then LEFT at (0,0) with WRAP=0 -> cursor stays (0,0), err=0. Repeat with WRAP=1 -> cursor (7,0).
- RIGHT x3, DOWN x2, SELECT -> selected=1, sel=(3,2), op_ready=1. SELECT again -> next cycle elim_req=1, op_ready=0. Ack after 5 cycles -> IDLE, selected=0, move_cnt=1.
- Select (3,2), UP -> swap_req=1, tgt=(3,1), cursor=(3,1). swap_ack with swap_ok=0 -> err pulse, cursor=(3,2), still selected. Repeat with swap_ok=1 -> move_cnt increments, selected=0.
- Select (0,0), LEFT -> err pulse, no swap_req, state SEL, even with WRAP=1.
- SELECT twice with no ack -> after ACK_TIMEOUT cycles elim_req drops, err pulse, back in SEL. Also check ack arriving on the timeout cycle -> treated as a success.
- Assert rst_n low while swap_req=1 -> all outputs return to reset values immediately. Also check move_cnt saturation with CNT_W=2 after 5 moves -> 3.
